// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write and hazard-query bundle for regfile_wb_arbiter.
// The master side belongs to the requesters and the issue stage; the slave side belongs to the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_SRC-1:0]        req_valid;
  logic [NUM_SRC*ADDR_W-1:0] req_rd;
  logic [NUM_SRC*DATA_W-1:0] req_data;
  logic [NUM_SRC-1:0]        req_ready;
  logic                      wb_regWrite;
  logic [ADDR_W-1:0]         wb_rd;
  logic [DATA_W-1:0]         wb_data;
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_rd;
  logic [ADDR_W-1:0]         chk_rs1;
  logic [ADDR_W-1:0]         chk_rs2;
  logic                      stall;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  req_ready, wb_regWrite, wb_rd, wb_data, stall
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1, chk_rs2,
    output req_ready, wb_regWrite, wb_rd, wb_data, stall
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_SRC writeback sources,
// with a pending-write scoreboard that stalls issue on RAW hazards until the write lands.
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NUM_REG = 1 << ADDR_W;

  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic               grant_found_s;
  logic               xfer_s;
  logic [NUM_SRC-1:0] ready_s;
  logic [ADDR_W-1:0]  grant_rd_s;
  logic [DATA_W-1:0]  grant_data_s;
  logic               wb_we_r;
  logic [ADDR_W-1:0]  wb_rd_r;
  logic [DATA_W-1:0]  wb_data_r;
  logic [NUM_REG-1:0] pending_r;
  logic [NUM_REG-1:0] set_mask_s;
  logic [NUM_REG-1:0] clr_mask_s;
  logic [NUM_REG-1:0] pending_next_s;

  // First valid source at or after rr_ptr, wrapping around
  always_comb begin
    int  cand_v;
    logic hit_v;
    cand_v        = 0;
    hit_v         = 1'b0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_v        = (int'(rr_ptr_r) + k) % NUM_SRC;
      hit_v         = !grant_found_s && bus.req_valid[cand_v];
      grant_idx_s   = hit_v ? IDX_W'(cand_v) : grant_idx_s;
      grant_found_s = grant_found_s | hit_v;
    end
  end

  assign xfer_s       = grant_found_s && !rst;
  assign grant_rd_s   = bus.req_rd[int'(grant_idx_s)*ADDR_W +: ADDR_W];
  assign grant_data_s = bus.req_data[int'(grant_idx_s)*DATA_W +: DATA_W];

  // One-hot ready for the granted source and the pointer value that follows it
  always_comb begin
    ready_s = '0;
    if (xfer_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
    if (int'(grant_idx_s) == NUM_SRC - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + 1'b1;
    end
  end

  // Round-robin pointer and registered register-file write port
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= '0;
      wb_we_r   <= 1'b0;
      wb_rd_r   <= '0;
      wb_data_r <= '0;
    end else begin
      wb_we_r <= xfer_s && (grant_rd_s != '0);
      if (xfer_s) begin
        rr_ptr_r  <= next_ptr_s;
        wb_rd_r   <= grant_rd_s;
        wb_data_r <= grant_data_s;
      end
    end
  end

  // Set is applied after clear so a newer producer to the same register stays outstanding
  always_comb begin
    set_mask_s     = (bus.issue_valid && (bus.issue_rd != '0)) ? (NUM_REG'(1) << bus.issue_rd) : '0;
    clr_mask_s     = wb_we_r ? (NUM_REG'(1) << wb_rd_r) : '0;
    pending_next_s = (pending_r & ~clr_mask_s) | set_mask_s;
  end

  // Pending-write scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.wb_regWrite = wb_we_r;
  assign bus.wb_rd       = wb_rd_r;
  assign bus.wb_data     = wb_data_r;
  assign bus.stall       = ((bus.chk_rs1 != '0) && pending_r[bus.chk_rs1]) ||
                           ((bus.chk_rs2 != '0) && pending_r[bus.chk_rs2]);
endmodule
